// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encoding and TX state codes.
// The RX side imports the same package so both ends agree on the parity polarity.
package uart_pkg;

    localparam logic EVEN_PARITY = 1'b0;
    localparam logic ODD_PARITY  = 1'b1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // xor_all is the reduction XOR of the data word.
    function automatic logic parity_bit(input logic parity_type, input logic xor_all);
        return (parity_type == ODD_PARITY) ? ~xor_all : xor_all;
    endfunction

endpackage

// File: rtl/tx_serializer.sv
// Shift register and bit counter for the UART transmitter data phase.
// The shift register shifts right, so data leaves the line LSB first.
module tx_serializer #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [width-1:0] data_in,
    output logic             ser_bit,
    output logic             last_bit
);

    localparam int CntW = $clog2(width);

    logic [width-1:0] sr_q;
    logic [CntW-1:0]  cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sr_q  <= data_in;
            cnt_q <= '0;
        end else if (shift) begin
            sr_q  <= {1'b0, sr_q[width-1:1]};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Bit that will sit in the LSB after this edge, so the caller can register it directly.
    assign ser_bit  = shift ? sr_q[1] : sr_q[0];
    assign last_bit = (cnt_q == CntW'(width - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit at one bit per clk.
// TX_out and Busy are both driven from flops loaded with the value for the next state.
module uart_tx
    import uart_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] P_Data,
    input  logic             Data_Valid,
    input  logic             Par_en,
    input  logic             Parity_Type,
    output logic             TX_out,
    output logic             Busy
);

    logic [2:0] state_q, state_d;
    logic       tx_q, tx_d;
    logic       busy_q;
    logic       par_en_q;
    logic       par_bit_q;
    logic       accept;
    logic       shift;
    logic       ser_bit;
    logic       last_bit;

    assign accept = (state_q == IDLE) && Data_Valid;
    // The first data bit comes straight from the freshly loaded LSB, so no shift on START -> DATA.
    assign shift  = (state_q == DATA) && !last_bit;

    tx_serializer #(
        .width(width)
    ) u_serializer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .shift   (shift),
        .data_in (P_Data),
        .ser_bit (ser_bit),
        .last_bit(last_bit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Data_Valid) state_d = START;
            START:   state_d = DATA;
            DATA:    if (last_bit) state_d = par_en_q ? PARITY : STOP;
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = ser_bit;
            PARITY:  tx_d = par_bit_q;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != IDLE);
            if (accept) begin
                par_en_q  <= Par_en;
                par_bit_q <= parity_bit(Parity_Type, ^P_Data);
            end
        end
    end

    assign TX_out = tx_q;
    assign Busy   = busy_q;

endmodule
